// File: rtl/fir_mul_pipe_sat.sv
// Pipelined signed multiplier with stall handshake, scaling and saturation.
// Optional macro FIR_MUL_ROUND_EN: round half up before the right shift.
module fir_mul_pipe_sat #(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 2,
   parameter int din0_WIDTH = 16,
   parameter int din1_WIDTH = 9,
   parameter int dout_WIDTH = 16,
   parameter int SHIFT      = 8
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  sat,
   output logic                  ovf_sticky,
   input  logic                  clr_ovf
);

   localparam int W  = din0_WIDTH + din1_WIDTH;
   localparam int D  = NUM_STAGE - 1;
   localparam int DW = dout_WIDTH;

   localparam logic [DW-1:0] DMAX = {1'b0, {(DW-1){1'b1}}};
   localparam logic [DW-1:0] DMIN = {1'b1, {(DW-1){1'b0}}};

   logic                stall;
   logic                accept;
   logic signed [W-1:0] prod;
   logic signed [W-1:0] last_p;
   logic                last_v;
   logic signed [W:0]   ext;
   logic signed [W:0]   scaled;
   logic [W-DW+1:0]     top;
   logic [DW-1:0]       sat_val;
   logic                sat_hit;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;
   assign accept   = in_valid && in_ready;
   assign prod     = W'($signed(din0)) * W'($signed(din1));

   generate
      if (D > 0) begin : g_pipe
         logic signed [W-1:0] p_q [D];
         logic [D-1:0]        v_q;

         // stage valid bits advance together, bubbles included
         always_ff @(posedge ap_clk) begin
            if (ap_rst) begin
               v_q <= '0;
            end else if (!stall) begin
               v_q[0] <= accept;
               for (int i = 1; i < D; i++) begin
                  v_q[i] <= v_q[i-1];
               end
            end
         end

         // product enters stage 1 and rides along with its valid bit
         always_ff @(posedge ap_clk) begin
            if (!stall) begin
               p_q[0] <= prod;
               for (int i = 1; i < D; i++) begin
                  p_q[i] <= p_q[i-1];
               end
            end
         end

         assign last_p = p_q[D-1];
         assign last_v = v_q[D-1];
      end else begin : g_comb
         assign last_p = prod;
         assign last_v = accept;
      end
   endgenerate

`ifdef FIR_MUL_ROUND_EN
   localparam logic [W:0] RND = ((W+1)'(1) << SHIFT) >> 1;
   assign ext = {last_p[W-1], last_p} + RND;
`else
   assign ext = {last_p[W-1], last_p};
`endif

   assign scaled = ext >>> SHIFT;
   assign top    = scaled[W:DW-1];

   // clamp to the output range when the upper bits are not a pure sign run
   always_comb begin
      sat_hit = !((&top) || (~|top));
      sat_val = scaled[DW-1:0];
      if (sat_hit) begin
         sat_val = scaled[W] ? DMIN : DMAX;
      end
   end

   // output stage; dout and sat only move when a real result arrives
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         out_valid <= 1'b0;
         dout      <= '0;
         sat       <= 1'b0;
      end else if (!stall) begin
         out_valid <= last_v;
         if (last_v) begin
            dout <= sat_val;
            sat  <= sat_hit;
         end
      end
   end

   // overflow flag: clear beats a same-cycle saturated transfer
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         ovf_sticky <= 1'b0;
      end else if (clr_ovf) begin
         ovf_sticky <= 1'b0;
      end else if (out_valid && out_ready && sat) begin
         ovf_sticky <= 1'b1;
      end
   end

endmodule

// File: doc/fir_mul_pipe_sat.md
Name: fir_mul_pipe_sat

Overview:
- Parametrised, pipelined signed multiplier for the FIR datapath. Successor to the single-cycle combinational tap multipliers.
- Adds configurable latency, a valid/ready handshake with full-pipeline stall, arithmetic right-shift scaling, and saturation to the output width with overflow reporting.
- Sits between coefficient/sample fetch and the accumulator chain of the transposed FIR.

Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 2, pipeline depth in cycles; legal range 1..6.
- din0_WIDTH, 16, sample operand width (signed).
- din1_WIDTH, 9, coefficient operand width (signed).
- dout_WIDTH, 16, result width (signed); must be at most din0_WIDTH+din1_WIDTH.
- SHIFT, 8, arithmetic right shift applied to the full product; legal range 0..din0_WIDTH+din1_WIDTH-1.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- din0  in  din0_WIDTH  signed sample.
- din1  in  din1_WIDTH  signed coefficient.
- out_valid  out  1  dout valid.
- out_ready  in  1  downstream accepts dout.
- dout  out  dout_WIDTH  scaled, saturated product.
- sat  out  1  dout was saturated; aligned with dout.
- ovf_sticky  out  1  set on any saturated transfer; cleared by reset or clr_ovf.
- clr_ovf  in  1  synchronous clear of ovf_sticky.

Behaviour:
- Reset: ap_rst high at a clock edge clears every stage valid bit, dout, sat and ovf_sticky to 0. in_ready is 1 in the first cycle after reset. Reset mid-operation discards all in-flight data.
- Stall rule: stall = out_valid && !out_ready. in_ready = !stall (combinational).
- When not stalled, every stage advances by one, including bubbles; bubbles are not collapsed.
- When stalled, all stage registers, dout and sat hold their values.
- An operand pair is accepted when in_valid && in_ready. Its result appears with out_valid=1 exactly NUM_STAGE cycles later, provided no stall occurs in between; each stall cycle adds one cycle.
- A result transfers when out_valid && out_ready.
- Arithmetic:
  - P = signed(din0) * signed(din1), computed at full width W = din0_WIDTH+din1_WIDTH.
  - S = P >>> SHIFT (arithmetic shift; truncation toward minus infinity by default).
  - If S > 2^(dout_WIDTH-1)-1, dout = max positive and sat = 1.
  - If S < -2^(dout_WIDTH-1), dout = min negative and sat = 1.
  - Otherwise dout = S and sat = 0.
- Placement: the multiply is in stage 1; shift, round and saturate are in the last stage. With NUM_STAGE=1, all of it is in one stage.
- ovf_sticky:
  - Set on the cycle a transfer occurs with sat=1.
  - clr_ovf has priority over a same-cycle set, and the set is lost.
  - ovf_sticky stays set until cleared.
- Idle: with in_valid low, out_valid drops after the last result is transferred; dout holds its last value.
- The bench checks dout only when out_valid=1.

Optional Feature:
- Macro: FIR_MUL_ROUND_EN.
- Defined: round half toward plus infinity before the shift. S = (P + 2^(SHIFT-1)) >>> SHIFT for SHIFT>0, computed at W+1 bits so there is no internal wrap; saturation then applies to this S.
- Undefined: pure truncation as above.
- With SHIFT=0 the two modes are identical.

Test Plan (defaults unless noted; out_ready=1 unless noted):
- Reset: hold ap_rst 2 cycles with in_valid=1 -> out_valid=0, dout=0, sat=0, ovf_sticky=0. in_ready=1 the cycle after release.
- Basic latency: din0=1000, din1=100 accepted at cycle t -> out_valid=1 at t+2. dout=390 (truncate) or 391 (FIR_MUL_ROUND_EN).
- Negative and rounding: din0=-640, din1=1 -> dout=-3 (truncate) or -2 (rounded). din0=-1000, din1=1 -> dout=-4 in both modes.
- Saturation and sticky flag: din0=-32768, din1=-256 -> dout=32767, sat=1; ovf_sticky=1 after transfer. Then din0=-32768, din1=255 -> dout=-32640, sat=0, ovf_sticky still 1. Pulse clr_ovf -> 0. clr_ovf asserted in the same cycle as a saturated transfer -> ovf_sticky stays 0.
- Backpressure: stream 5 pairs back-to-back and drop out_ready for 3 cycles mid-stream -> in_ready=0 and dout/sat stable during the stall. All 5 results emerge in order with no loss or duplication.
- Reset mid-stream: assert ap_rst with 2 results in flight -> no stale out_valid after reset. The next accepted pair emerges after exactly NUM_STAGE cycles. Repeat the latency test with NUM_STAGE=1 and NUM_STAGE=4.
